// File: rtl/spi_neopix_multi.sv
// Shared SPI slave that loads per-channel staging buffers, with an independent
// WS2812 serializer per channel driving DO from the last committed frame.
module spi_neopix_multi #(
    parameter int NUM_CH   = 2,
    parameter int NUM_LEDS = 8,
    parameter int BPP      = 24,
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int BIT_CYC  = 63,
    parameter int RST_CYC  = 3000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic [NUM_CH-1:0] SSEL,
    output logic [NUM_CH-1:0] DO,
    output logic [NUM_CH-1:0] BUSY,
    output logic [NUM_CH-1:0] ERR
);
    localparam int FB   = NUM_LEDS * BPP;
    localparam int RXW  = $clog2(FB + 2);
    localparam int IDXW = $clog2(FB + 1);
    localparam int CMAX = (RST_CYC > BIT_CYC) ? RST_CYC : BIT_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CW-1:0]   C_T0H    = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0]   C_T1H    = CW'(T1H_CYC - 1);
    localparam logic [CW-1:0]   C_T0L    = CW'(BIT_CYC - T0H_CYC - 1);
    localparam logic [CW-1:0]   C_T1L    = CW'(BIT_CYC - T1H_CYC - 1);
    localparam logic [CW-1:0]   C_GAP    = CW'(RST_CYC - 1);
    localparam logic [RXW-1:0]  RX_FULL  = RXW'(FB);
    localparam logic [RXW-1:0]  RX_SAT   = RXW'(FB + 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(FB - 1);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

    logic              r_sck_m, r_sck_s, r_sck_d;
    logic              r_mosi_m, r_mosi_s;
    logic [NUM_CH-1:0] r_ssel_m, r_ssel_s, r_ssel_d;
    logic              r_act;
    logic [CHW-1:0]    r_act_ch;
    logic [RXW-1:0]    r_rx_cnt;
    logic [NUM_CH-1:0] r_err;

    logic              w_sck_rise, w_any_fall, w_rel;
    logic [CHW-1:0]    w_sel_ch;
    logic [NUM_CH-1:0] w_select, w_commit;
    logic [IDXW-1:0]   w_wr_idx;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sck_m  <= 1'b0;
            r_sck_s  <= 1'b0;
            r_sck_d  <= 1'b0;
            r_mosi_m <= 1'b0;
            r_mosi_s <= 1'b0;
            r_ssel_m <= '1;
            r_ssel_s <= '1;
            r_ssel_d <= '1;
        end else begin
            r_sck_m  <= SCK;
            r_sck_s  <= r_sck_m;
            r_sck_d  <= r_sck_s;
            r_mosi_m <= MOSI;
            r_mosi_s <= r_mosi_m;
            r_ssel_m <= SSEL;
            r_ssel_s <= r_ssel_m;
            r_ssel_d <= r_ssel_s;
        end
    end

    assign w_sck_rise = r_sck_s & ~r_sck_d;
    assign w_any_fall = |(r_ssel_d & ~r_ssel_s);
    assign w_rel      = r_act & r_ssel_s[r_act_ch] & ~r_ssel_d[r_act_ch];
    // first received bit lands in the MSB so the serializer can shift left
    assign w_wr_idx   = IDXW'(FB - 1) - IDXW'(r_rx_cnt);

    always_comb begin
        w_sel_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!r_ssel_s[i]) w_sel_ch = CHW'(i);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            w_select[i] = ~r_act & w_any_fall & (w_sel_ch == CHW'(i));
            w_commit[i] = w_rel & (r_act_ch == CHW'(i)) & (r_rx_cnt == RX_FULL);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_act    <= 1'b0;
            r_act_ch <= '0;
            r_rx_cnt <= '0;
            r_err    <= '0;
        end else begin
            r_err <= '0;
            if (!r_act) begin
                if (w_any_fall) begin
                    r_act    <= 1'b1;
                    r_act_ch <= w_sel_ch;
                    r_rx_cnt <= '0;
                end
            end else if (w_rel) begin
                r_act <= 1'b0;
                if (r_rx_cnt != RX_FULL) r_err[r_act_ch] <= 1'b1;
            end else if (w_sck_rise && r_rx_cnt != RX_SAT) begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
        end
    end

    assign ERR = r_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t          r_state, w_nxt;
        logic [CW-1:0]   r_cnt, w_nxt_cnt;
        logic [IDXW-1:0] r_idx, w_nxt_idx;
        logic [FB-1:0]   r_stage, r_disp;
        logic            r_pend, r_do, r_busy;
        logic            w_start, w_shift, w_wr;

        assign w_wr = r_act & (r_act_ch == CHW'(g)) & w_sck_rise & (r_rx_cnt < RX_FULL);

        // buffers are never transmitted without a fresh commit, so no reset
        always_ff @(posedge CLK) begin
            if (w_wr) r_stage[w_wr_idx] <= r_mosi_s;
            if (w_start)      r_disp <= r_stage;
            else if (w_shift) r_disp <= {r_disp[FB-2:0], 1'b0};
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_pend  <= 1'b0;
                r_do    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_state <= w_nxt;
                r_cnt   <= w_nxt_cnt;
                r_idx   <= w_nxt_idx;
                r_do    <= (w_nxt == S_HIGH);
                r_busy  <= (w_nxt != S_IDLE);
                if (w_commit[g])                r_pend <= 1'b1;
                else if (w_select[g] || w_start) r_pend <= 1'b0;
            end
        end

        always_comb begin
            w_nxt     = r_state;
            w_nxt_cnt = r_cnt;
            w_nxt_idx = r_idx;
            w_start   = 1'b0;
            w_shift   = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pend) begin
                        w_start   = 1'b1;
                        w_nxt     = S_HIGH;
                        w_nxt_idx = '0;
                        w_nxt_cnt = r_stage[FB-1] ? C_T1H : C_T0H;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == '0) begin
                        w_nxt     = S_LOW;
                        w_nxt_cnt = r_disp[FB-1] ? C_T1L : C_T0L;
                    end else begin
                        w_nxt_cnt = r_cnt - 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_cnt != '0) begin
                        w_nxt_cnt = r_cnt - 1'b1;
                    end else if (r_idx == IDX_LAST) begin
                        w_nxt     = S_GAP;
                        w_nxt_cnt = C_GAP;
                    end else begin
                        w_shift   = 1'b1;
                        w_nxt     = S_HIGH;
                        w_nxt_idx = r_idx + 1'b1;
                        w_nxt_cnt = r_disp[FB-2] ? C_T1H : C_T0H;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) w_nxt = S_IDLE;
                    else             w_nxt_cnt = r_cnt - 1'b1;
                end
                default: w_nxt = S_IDLE;
            endcase
        end

        assign DO[g]   = r_do;
        assign BUSY[g] = r_busy;
    end
endmodule

// File: tb/tb_spi_neopix_multi.sv
// Bench for spi_neopix_multi: a frame-level model predicts DO/BUSY/ERR every
// cycle; directed scenarios add literal pulse/cycle counts, then random traffic.
module tb_spi_neopix_multi;
    localparam int FB        = 48;
    localparam int FRAME_CYC = FB * 63 + 3000;

    logic       CLK = 1'b0, RST_N = 1'b1, SCK = 1'b0, MOSI = 1'b0;
    logic [1:0] SSEL = 2'b11;
    logic [1:0] DO, BUSY, ERR;

    int n_tests = 0, n_fail = 0, cyc = 0;
    bit chk_en = 1'b0;

    spi_neopix_multi #(
        .NUM_CH(2), .NUM_LEDS(2), .BPP(24),
        .T0H_CYC(20), .T1H_CYC(40), .BIT_CYC(63), .RST_CYC(3000)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .SCK(SCK), .MOSI(MOSI),
        .SSEL(SSEL), .DO(DO), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef enum {EV_SEL, EV_COMMIT, EV_ERR} ev_kind_t;
    typedef struct {
        int          t;
        int          ch;
        ev_kind_t    k;
        logic [47:0] d;
    } ev_t;
    ev_t ev_q[$];

    // Model: a commit/select/discard takes effect 3 cycles after the SSEL edge is
    // driven (2 sync flops + edge detect); a frame goes out on the cycle after
    // both the commit is visible and the channel has been idle.
    bit          m_pend[2];
    int          m_pend_c[2];
    logic [47:0] m_pend_d[2];
    int          m_e[2];
    int          m_start[2];
    logic [47:0] m_data[2];
    int          m_err_t[2];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pend[c]  = 1'b0;
            m_e[c]     = 0;
            m_start[c] = -1;
            m_err_t[c] = -1;
        end
        ev_q.delete();
    endfunction

    function automatic void expect_wave(input int ch, input int t, output bit e_do, output bit e_busy);
        int d;
        e_do   = 1'b0;
        e_busy = 1'b0;
        if (m_start[ch] >= 0) begin
            d = t - m_start[ch];
            if (d >= 0 && d < FRAME_CYC) begin
                e_busy = 1'b1;
                if (d < FB * 63)
                    e_do = ((d % 63) < (m_data[ch][47 - d / 63] ? 40 : 20));
            end
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            if (!RST_N) begin
                model_reset();
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (m_pend[c] && cyc > m_pend_c[c] && cyc > m_e[c]) begin
                        m_start[c] = cyc;
                        m_data[c]  = m_pend_d[c];
                        m_e[c]     = cyc + FRAME_CYC;
                        m_pend[c]  = 1'b0;
                    end
                end
                while (ev_q.size() > 0 && ev_q[0].t <= cyc) begin
                    ev_t e;
                    e = ev_q.pop_front();
                    case (e.k)
                        EV_SEL:    m_pend[e.ch] = 1'b0;
                        EV_COMMIT: begin
                            m_pend[e.ch]   = 1'b1;
                            m_pend_c[e.ch] = e.t;
                            m_pend_d[e.ch] = e.d;
                        end
                        default:   m_err_t[e.ch] = e.t;
                    endcase
                end
            end
            for (int c = 0; c < 2; c++) begin
                bit e_do, e_busy;
                expect_wave(c, cyc, e_do, e_busy);
                chk($sformatf("DO[%0d]", c), int'(DO[c]), int'(e_do));
                chk($sformatf("BUSY[%0d]", c), int'(BUSY[c]), int'(e_busy));
                chk($sformatf("ERR[%0d]", c), int'(ERR[c]), (m_err_t[c] == cyc) ? 1 : 0);
            end
        end
    end

    int   hi0 = 0, hi1 = 0, rise0 = 0, rise1 = 0, bz0 = 0, bz1 = 0, er0 = 0, er1 = 0;
    logic p0 = 1'b0, p1 = 1'b0;
    always @(negedge CLK) begin
        if (DO[0]) hi0++;
        if (DO[1]) hi1++;
        if (DO[0] && !p0) rise0++;
        if (DO[1] && !p1) rise1++;
        if (BUSY[0]) bz0++;
        if (BUSY[1]) bz1++;
        if (ERR[0]) er0++;
        if (ERR[1]) er1++;
        p0 = DO[0];
        p1 = DO[1];
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push(input int ch, input ev_kind_t k, input logic [47:0] d);
        ev_t e;
        e.t  = cyc + 3;
        e.ch = ch;
        e.k  = k;
        e.d  = d;
        ev_q.push_back(e);
    endtask

    task automatic spi_frame(input logic [1:0] low_mask, input int ch, input int nbits, input logic [63:0] d);
        SSEL = ~low_mask;
        push(ch, EV_SEL, '0);
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            MOSI = d[nbits - 1 - i];
            tick(4);
            SCK = 1'b1;
            tick(4);
            SCK = 1'b0;
        end
        tick(4);
        SSEL = 2'b11;
        if (nbits == FB) push(ch, EV_COMMIT, d[47:0]);
        else             push(ch, EV_ERR, '0);
        tick(4);
    endtask

    int s_hi0, s_hi1, s_rise0, s_rise1, s_bz0, s_bz1, s_er0, s_er1;
    task automatic snap();
        s_hi0 = hi0; s_hi1 = hi1; s_rise0 = rise0; s_rise1 = rise1;
        s_bz0 = bz0; s_bz1 = bz1; s_er0 = er0; s_er1 = er1;
    endtask

    initial begin
        model_reset();
        #1 RST_N = 1'b0;
        chk_en = 1'b1;
        tick(3);
        chk("reset DO", int'(DO), 0);
        chk("reset BUSY", int'(BUSY), 0);
        chk("reset ERR", int'(ERR), 0);
        RST_N = 1'b1;
        tick(5);

        // valid frame 0xFF0000_00FF00 on channel 0
        snap();
        spi_frame(2'b01, 0, 48, 64'h0000_FF00_0000_FF00);
        tick(FRAME_CYC + 100);
        chk("frame0 DO0 high cycles", hi0 - s_hi0, 1280);
        chk("frame0 DO0 pulses", rise0 - s_rise0, 48);
        chk("frame0 BUSY0 cycles", bz0 - s_bz0, FRAME_CYC);
        chk("frame0 DO1 high cycles", hi1 - s_hi1, 0);
        chk("frame0 BUSY1 cycles", bz1 - s_bz1, 0);

        // short and long frames on channel 1
        snap();
        spi_frame(2'b10, 1, 40, {$urandom, $urandom});
        spi_frame(2'b10, 1, 50, {$urandom, $urandom});
        tick(20);
        chk("length err ERR1 pulses", er1 - s_er1, 2);
        chk("length err DO1 high cycles", hi1 - s_hi1, 0);
        chk("length err BUSY1 cycles", bz1 - s_bz1, 0);

        // both selects fall together: channel 0 wins
        snap();
        spi_frame(2'b11, 0, 48, {$urandom, $urandom});
        tick(FRAME_CYC + 100);
        chk("simul sel DO0 pulses", rise0 - s_rise0, 48);
        chk("simul sel DO1 pulses", rise1 - s_rise1, 0);
        chk("simul sel ERR1 pulses", er1 - s_er1, 0);
        chk("simul sel ERR0 pulses", er0 - s_er0, 0);

        // A, then B and C while A is on the wire: only A and C go out
        snap();
        spi_frame(2'b01, 0, 48, {$urandom, $urandom});
        tick(200);
        spi_frame(2'b01, 0, 48, {$urandom, $urandom});
        tick(200);
        spi_frame(2'b01, 0, 48, {$urandom, $urandom});
        tick(2 * FRAME_CYC - 1000);
        chk("busy commits DO0 pulses", rise0 - s_rise0, 96);
        chk("busy commits BUSY0 cycles", bz0 - s_bz0, 2 * FRAME_CYC);

        // reset during bit 10
        spi_frame(2'b01, 0, 48, {$urandom, $urandom});
        tick(10 * 63 + 20);
        chk("pre-reset BUSY0", int'(BUSY[0]), 1);
        RST_N = 1'b0;
        #1;
        chk("async reset DO0", int'(DO[0]), 0);
        chk("async reset BUSY0", int'(BUSY[0]), 0);
        tick(3);
        RST_N = 1'b1;
        snap();
        tick(5000);
        chk("post-reset DO0 high cycles", hi0 - s_hi0, 0);
        chk("post-reset BUSY0 cycles", bz0 - s_bz0, 0);

        // overlapping transmissions on both channels
        snap();
        spi_frame(2'b01, 0, 48, {$urandom, $urandom});
        spi_frame(2'b10, 1, 48, {$urandom, $urandom});
        tick(FRAME_CYC + 200);
        chk("overlap DO0 pulses", rise0 - s_rise0, 48);
        chk("overlap DO1 pulses", rise1 - s_rise1, 48);

        // random traffic
        for (int n = 0; n < 12; n++) begin
            int ch, len;
            ch  = int'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) != 0) ? FB : int'($urandom_range(40, 52));
            spi_frame((ch == 1) ? 2'b10 : 2'b01, ch, len, {$urandom, $urandom});
            tick(int'($urandom_range(0, 400)));
        end
        tick(2 * FRAME_CYC + 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
